// File: rtl/dpad_event_arbiter.sv
// D-pad release detector: round-robin serialisation of button releases into a
// small event FIFO with valid/ready delivery, plus an inactivity timeout pulse.
module dpad_event_arbiter #(
  parameter int unsigned TIMEOUT_W  = 25,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  output logic                          evt_valid,
  output logic [1:0]                    evt_code,
  input  logic                          evt_ready,
  output logic                          timeout,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [3:0]                       btn;
  logic [3:0]                       s0_q, s0_d, s1_q, s1_d;
  logic [3:0]                       rel;
  logic [3:0]                       pend_q, pend_d;
  logic [1:0]                       rr_q, rr_d;
  logic                             ovf_q, ovf_d;
  logic [FIFO_DEPTH-1:0][1:0]       mem_q, mem_d;
  logic [PTR_W-1:0]                 wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             valid_q, valid_d;
  logic                             tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]             idle_q, idle_d;

  logic                             full;
  logic                             gnt;
  logic [1:0]                       gnt_idx;
  logic [1:0]                       idx;
  logic [3:0]                       gnt_mask;
  logic                             pop;

  assign btn = {right, left, down, up};

  // Round-robin scan of the pending mask starting at rr; blocked while full.
  always_comb begin
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    gnt      = 1'b0;
    gnt_idx  = 2'd0;
    idx      = 2'd0;
    gnt_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!gnt && !full && pend_q[idx]) begin
        gnt     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt) gnt_mask[gnt_idx] = 1'b1;
  end

  always_comb begin
    s0_d  = btn;
    s1_d  = s0_q;
    rel   = s1_q & ~s0_q;
    // A release on a bit being granted this cycle simply re-arms it.
    pend_d = (pend_q & ~gnt_mask) | rel;
    ovf_d  = ovf_q | (|(rel & pend_q & ~gnt_mask));
    rr_d   = gnt ? gnt_idx + 2'd1 : rr_q;

    pop   = valid_q && evt_ready;
    mem_d = mem_q;
    if (gnt) mem_d[wr_q] = gnt_idx;
    wr_d    = gnt ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d   = cnt_q + CNT_W'(gnt) - CNT_W'(pop);
    valid_d = (cnt_d != '0);

    idle_d = (|rel) ? '0 : idle_q + TIMEOUT_W'(1);
    tmo_d  = &idle_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q    <= '0;
      s1_q    <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_code   = mem_q[rd_q];
  assign timeout    = tmo_q;
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_dpad_event_arbiter.sv
// Directed bench for dpad_event_arbiter (TIMEOUT_W = 4, FIFO_DEPTH = 4).
module tb_dpad_event_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       timeout;
  logic       overflow;
  logic [2:0] fifo_count;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  dpad_event_arbiter #(.TIMEOUT_W(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (btn[0]),
    .down      (btn[1]),
    .left      (btn[2]),
    .right     (btn[3]),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .timeout   (timeout),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Press mask for 3 cycles then release; first push is visible 3 ticks later.
  task automatic press_release(input logic [3:0] mask);
    btn = mask;
    tick(3);
    btn = 4'b0000;
  endtask

  initial begin
    // Reset state
    tick(2);
    reset = 1'b0;
    chk("rst_valid",    32'(evt_valid),  32'd0);
    chk("rst_code",     32'(evt_code),   32'd0);
    chk("rst_timeout",  32'(timeout),    32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);

    // Idle timeout: pulse 15 cycles after reset, then every 16
    tick(14);
    chk("tmo_pre",   32'(timeout), 32'd0);
    tick(1);
    chk("tmo_first", 32'(timeout), 32'd1);
    tick(1);
    chk("tmo_single_cycle", 32'(timeout), 32'd0);
    tick(15);
    chk("tmo_second", 32'(timeout), 32'd1);

    // Release at cycle 10 restarts the idle count
    do_reset();
    btn = 4'b0001;
    tick(8);
    btn = 4'b0000;
    tick(1);
    chk("tmo_rel_valid_early", 32'(evt_valid), 32'd0);
    tick(2);
    chk("tmo_rel_pushed", 32'(fifo_count), 32'd1);
    tick(4);
    chk("tmo_suppressed", 32'(timeout), 32'd0);
    tick(9);
    chk("tmo_delay_pre", 32'(timeout), 32'd0);
    tick(1);
    chk("tmo_delayed", 32'(timeout), 32'd1);

    // Single release with consumer ready
    do_reset();
    evt_ready = 1'b1;
    press_release(4'b0001);
    tick(2);
    chk("single_not_yet", 32'(evt_valid), 32'd0);
    tick(1);
    chk("single_valid", 32'(evt_valid), 32'd1);
    chk("single_code",  32'(evt_code),  32'd0);
    tick(1);
    chk("single_one_cycle", 32'(evt_valid), 32'd0);
    chk("single_timeout",   32'(timeout),   32'd0);

    // Simultaneous release of all four, rr = 0
    do_reset();
    evt_ready = 1'b0;
    press_release(4'b1111);
    tick(3);
    chk("sim_first_cnt",  32'(fifo_count), 32'd1);
    chk("sim_first_code", 32'(evt_code),   32'd0);
    tick(3);
    chk("sim_full_cnt", 32'(fifo_count), 32'd4);
    evt_ready = 1'b1;
    tick(1);
    chk("sim_drain1", 32'(evt_code), 32'd1);
    tick(1);
    chk("sim_drain2", 32'(evt_code), 32'd2);
    tick(1);
    chk("sim_drain3", 32'(evt_code), 32'd3);
    tick(1);
    chk("sim_empty", 32'(evt_valid), 32'd0);

    // Second burst: down and right, rr back at 0
    evt_ready = 1'b0;
    press_release(4'b1010);
    tick(3);
    chk("burst2_first", 32'(evt_code), 32'd1);
    tick(1);
    chk("burst2_cnt", 32'(fifo_count), 32'd2);
    evt_ready = 1'b1;
    tick(1);
    chk("burst2_second", 32'(evt_code), 32'd3);
    tick(1);
    chk("burst2_empty", 32'(fifo_count), 32'd0);

    // Fairness: rr = 0 after right grant; up then left; then rr = 3
    evt_ready = 1'b0;
    press_release(4'b0101);
    tick(4);
    chk("fair_cnt",   32'(fifo_count), 32'd2);
    chk("fair_first", 32'(evt_code),   32'd0);
    evt_ready = 1'b1;
    tick(1);
    chk("fair_second", 32'(evt_code), 32'd2);
    tick(1);
    evt_ready = 1'b0;
    press_release(4'b1001);
    tick(4);
    chk("fair_rr3_first", 32'(evt_code), 32'd3);
    evt_ready = 1'b1;
    tick(1);
    chk("fair_rr3_second", 32'(evt_code), 32'd0);
    tick(1);
    chk("fair_empty", 32'(evt_valid), 32'd0);

    // Back-pressure and overflow
    do_reset();
    evt_ready = 1'b0;
    press_release(4'b1111);
    tick(6);
    chk("bp_full", 32'(fifo_count), 32'd4);
    press_release(4'b0100);
    tick(3);
    chk("bp_blocked",   32'(fifo_count), 32'd4);
    chk("bp_no_ovf",    32'(overflow),   32'd0);
    press_release(4'b0100);
    tick(2);
    chk("bp_overflow", 32'(overflow), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("bp_pop_no_push", 32'(fifo_count), 32'd3);
    tick(1);
    chk("bp_refill", 32'(fifo_count), 32'd4);
    chk("bp_head",   32'(evt_code),   32'd1);
    tick(2);
    chk("bp_stable_code", 32'(evt_code), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    chk("bp_order2", 32'(evt_code), 32'd2);
    tick(1);
    chk("bp_order3", 32'(evt_code), 32'd3);
    tick(1);
    chk("bp_order4", 32'(evt_code), 32'd2);
    tick(1);
    chk("bp_empty",  32'(evt_valid), 32'd0);
    chk("bp_sticky", 32'(overflow),  32'd1);

    // Reset mid-stream with a button released during reset
    evt_ready = 1'b0;
    press_release(4'b0111);
    tick(5);
    chk("mid_queued", 32'(fifo_count), 32'd3);
    btn = 4'b1000;
    tick(2);
    btn   = 4'b0000;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_valid", 32'(evt_valid),  32'd0);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_ovf",   32'(overflow),   32'd0);
    chk("mid_tmo",   32'(timeout),    32'd0);
    tick(5);
    chk("mid_no_spurious", 32'(fifo_count), 32'd0);
    chk("mid_no_valid",    32'(evt_valid),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
